// File: rtl/pcd_tx_pkg.sv
// Shared types for the ISO/IEC 14443A reader transmitter: Miller symbols,
// frame FSM states and the modified-Miller coding rule.
package pcd_tx_pkg;

    typedef enum logic [1:0] {SYM_X, SYM_Y, SYM_Z} symbol_t;

    typedef enum logic [2:0] {IDLE, SOC, DATA, PARITY, EOC0, EOC1} tx_state_t;

    // prev_one is the previous coded bit; SOC counts as a 0.
    function automatic symbol_t miller_symbol(input logic b, input logic prev_one);
        if (b) return SYM_X;
        if (prev_one) return SYM_Y;
        return SYM_Z;
    endfunction

endpackage

// File: rtl/pcd_miller_symbol_gen.sv
// Plays one Miller symbol per BIT_PERIOD cycles onto a registered pause_n.
// load_i in any cycle makes the next cycle t=0 of sym_i; without it the stream stops.
module pcd_miller_symbol_gen
    import pcd_tx_pkg::*;
#(
    parameter int BIT_PERIOD = 128,
    parameter int PAUSE_LEN  = 32
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    load_i,
    input  symbol_t sym_i,
    output logic    sym_last_o,
    output logic    pause_n_o
);

    localparam int CW = $clog2(BIT_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] X_START  = CW'(BIT_PERIOD / 2);
    localparam logic [CW-1:0] X_END    = CW'(BIT_PERIOD / 2 + PAUSE_LEN);
    localparam logic [CW-1:0] Z_END    = CW'(PAUSE_LEN);

    if (BIT_PERIOD % 2 != 0 || BIT_PERIOD < 4) begin : g_bit_period_chk
        $error("BIT_PERIOD must be even and at least 4");
    end
    if (PAUSE_LEN < 1 || PAUSE_LEN >= BIT_PERIOD / 2) begin : g_pause_len_chk
        $error("PAUSE_LEN must be in 1..BIT_PERIOD/2-1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    symbol_t       sym_q, sym_d;
    logic          active_q, active_d;
    logic          pause_n_q, pause_n_d;
    logic          in_pause;

    // pause_n is computed from next-cycle symbol position so the flop lines up with t.
    always_comb begin
        sym_last_o = active_q && (cnt_q == CNT_LAST);
        active_d   = load_i || (active_q && !sym_last_o);
        cnt_d      = '0;
        sym_d      = sym_q;
        if (load_i) begin
            sym_d = sym_i;
        end else if (active_d) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (sym_d)
            SYM_X:   in_pause = (cnt_d >= X_START) && (cnt_d < X_END);
            SYM_Z:   in_pause = (cnt_d < Z_END);
            default: in_pause = 1'b0;
        endcase
        pause_n_d = !(active_d && in_pause);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            sym_q     <= SYM_Y;
            active_q  <= 1'b0;
            pause_n_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            sym_q     <= sym_d;
            active_q  <= active_d;
            pause_n_q <= pause_n_d;
        end
    end

    assign pause_n_o = pause_n_q;

endmodule

// File: rtl/pcd_frame_transmitter.sv
// ISO/IEC 14443A 106 kbit/s reader transmitter: byte stream in, modified-Miller
// pause_n out (SOC, LSB-first data, optional odd parity, EOC).
module pcd_frame_transmitter
    import pcd_tx_pkg::*;
#(
    parameter int BIT_PERIOD = 128,
    parameter int PAUSE_LEN  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_bits,
    input  logic       in_parity,
    input  logic       in_last,
    output logic       pause_n,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun,
    output tx_state_t  dbg_state
);

    tx_state_t  state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [3:0] rem_q, rem_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
    logic       last_q, last_d;
    logic       prev_q, prev_d;
    logic       done_q, done_d;
    logic       underrun_q, underrun_d;
    logic       load, sym_last, byte_end, take;
    symbol_t    sym;
    logic [3:0] in_nbits;

    assign in_nbits = (in_bits == 3'd0) ? 4'd8 : {1'b0, in_bits};

    pcd_miller_symbol_gen #(
        .BIT_PERIOD(BIT_PERIOD),
        .PAUSE_LEN (PAUSE_LEN)
    ) u_symgen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .sym_i     (sym),
        .sym_last_o(sym_last),
        .pause_n_o (pause_n)
    );

    // Handshake: a byte moves when in_valid && in_ready on a rising edge; in_ready
    // never depends on in_valid, and in_valid is ignored while in_ready is low.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rem_d      = rem_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        last_d     = last_q;
        prev_d     = prev_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;
        sym        = SYM_Y;
        in_ready   = 1'b0;
        byte_end   = ((state_q == DATA) || (state_q == PARITY)) && (rem_q == 4'd0)
                     && !((state_q == DATA) && par_en_q);
        case (state_q)
            IDLE:              in_ready = !done_q;
            SOC, DATA, PARITY: in_ready = sym_last && byte_end && !last_q;
            default:           in_ready = 1'b0;
        endcase
        if (rst) in_ready = 1'b0;
        take = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d   = SOC;
                    data_d    = in_data;
                    rem_d     = in_nbits;
                    par_en_d  = in_parity;
                    par_bit_d = ~^in_data;
                    last_d    = in_last;
                    prev_d    = 1'b0;
                    load      = 1'b1;
                    sym       = SYM_Z;
                end
            end
            SOC, DATA, PARITY: begin
                if (sym_last) begin
                    load = 1'b1;
                    if (rem_q != 4'd0) begin
                        state_d = DATA;
                        sym     = miller_symbol(data_q[0], prev_q);
                        prev_d  = data_q[0];
                        data_d  = {1'b0, data_q[7:1]};
                        rem_d   = rem_q - 4'd1;
                    end else if ((state_q == DATA) && par_en_q) begin
                        state_d = PARITY;
                        sym     = miller_symbol(par_bit_q, prev_q);
                        prev_d  = par_bit_q;
                    end else if (take) begin
                        // Next byte's first bit follows with no gap; coding history carries over.
                        state_d   = DATA;
                        sym       = miller_symbol(in_data[0], prev_q);
                        prev_d    = in_data[0];
                        data_d    = {1'b0, in_data[7:1]};
                        rem_d     = in_nbits - 4'd1;
                        par_en_d  = in_parity;
                        par_bit_d = ~^in_data;
                        last_d    = in_last;
                    end else begin
                        state_d    = EOC0;
                        sym        = miller_symbol(1'b0, prev_q);
                        prev_d     = 1'b0;
                        underrun_d = !last_q;
                    end
                end
            end
            EOC0: begin
                if (sym_last) begin
                    state_d = EOC1;
                    load    = 1'b1;
                    sym     = SYM_Y;
                end
            end
            EOC1: begin
                if (sym_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            rem_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            last_q     <= 1'b0;
            prev_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            rem_q      <= rem_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            last_q     <= last_d;
            prev_q     <= prev_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign underrun   = underrun_q;
    assign dbg_state  = state_q;

endmodule
